// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with majority-voted bits, optional parity and stop check
// Ports: CLK clock; RST synchronous active-high reset; RX_IN serial line (idles high);
//        PAR_EN/PAR_TYP parity enable/odd-select, latched at the start bit;
//        P_DATA last good word; data_valid/par_err/stp_err one-cycle outcome pulses;
//        busy high while a frame is in progress.
// Define RX_SYNC_EN to pass RX_IN through a 2-flop synchronizer (adds 2 cycles of latency).
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);
  localparam int EW = $clog2(PRESCALE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] SAMP_LO   = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] SAMP_HI   = EW'(PRESCALE / 2 + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  state_e                state_q, state_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [2:0]            samp_q, samp_d;
  logic                  pen_q, pen_d, ptyp_q, ptyp_d, perr_q, perr_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d;
  logic                  rx, bit_end, maj;
`ifdef RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge CLK) sync_q <= RST ? 2'b11 : {sync_q[0], RX_IN};
  assign rx = sync_q[1];
`else
  assign rx = RX_IN;
`endif
  assign bit_end = edge_q == LAST_EDGE;
  // samp_q holds the three mid-bit samples by the time the bit ends
  assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    samp_d  = samp_q;
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;
    perr_d  = perr_q;
    pdata_d = pdata_q;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    se_d    = 1'b0;
    if (state_q != IDLE) begin
      edge_d = bit_end ? '0 : edge_q + 1'b1;
      samp_d = (edge_q >= SAMP_LO && edge_q <= SAMP_HI) ? {samp_q[1:0], rx} : samp_q;
    end
    unique case (state_q)
      IDLE: if (!rx) begin
        // the detecting cycle is edge 0 of the start bit
        state_d = START;
        edge_d  = EW'(1);
        pen_d   = PAR_EN;
        ptyp_d  = PAR_TYP;
        perr_d  = 1'b0;
      end
      START: if (bit_end) begin
        state_d = maj ? IDLE : DATA;
        bit_d   = '0;
      end
      DATA: if (bit_end) begin
        shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
        bit_d   = bit_q + 1'b1;
        state_d = (bit_q != LAST_BIT) ? DATA : pen_q ? PARITY : STOP;
      end
      PARITY: if (bit_end) begin
        perr_d  = maj != (^shift_q ^ ptyp_q);
        state_d = STOP;
      end
      STOP: if (bit_end) begin
        state_d = IDLE;
        dv_d    = maj & ~perr_q;
        pe_d    = perr_q;
        se_d    = ~maj;
        pdata_d = (maj & ~perr_q) ? shift_q : pdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      samp_q  <= '0;
      pen_q   <= 1'b0;
      ptyp_q  <= 1'b0;
      perr_q  <= 1'b0;
      pdata_q <= '0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      samp_q  <= samp_d;
      pen_q   <= pen_d;
      ptyp_q  <= ptyp_d;
      perr_q  <= perr_d;
      pdata_q <= pdata_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
      se_q    <= se_d;
    end
  end
  assign P_DATA     = pdata_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;
  assign busy       = state_q != IDLE;
endmodule
